fetch_queue_unit: RTL and testbench

//  Parametrised instruction-fetch stage for the RV32IM pipeline: owns the PC, issues requests to i_cache,

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_queue_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM state encoding and the NOP filler.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_FULL    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0 -- presented downstream while the queue is empty
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc,instr} pairs; flush empties it in one cycle and wins over push/pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem[rd_ptr];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the PC, drives i_cache, queues {pc,instr} for IF/ID, flushes on redirect.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    input  logic [XLEN-1:0] IMEM_RDATA,
    input  logic            IMEM_BUSYWAIT,
    input  logic            REDIRECT,
    input  logic [XLEN-1:0] REDIRECT_PC,
    output logic            OUT_VALID,
    output logic [XLEN-1:0] OUT_PC,
    output logic [XLEN-1:0] OUT_INSTR,
    input  logic            OUT_READY,
    output logic [31:0]     PERF_STALL,
    output logic [31:0]     PERF_FLUSH
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t      state;
    logic              req_q;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   pending_pc;
    logic [XLEN-1:0]   target_pc;
    logic              fetch_done;
    logic              do_push;
    logic              do_pop;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*XLEN-1:0] head;
    logic              unused_redirect_lsb;

    assign target_pc           = {REDIRECT_PC[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^REDIRECT_PC[1:0];

    assign fetch_done = req_q && !IMEM_BUSYWAIT;
    assign do_push    = (state == ST_FETCH) && fetch_done && !REDIRECT;
    assign do_pop     = !fifo_empty && OUT_READY && !REDIRECT;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop)      count_next = count + CW'(1);
        else if (!do_push && do_pop) count_next = count - CW'(1);
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .reset (RESET),
        .push  (do_push),
        .wdata ({fetch_pc, IMEM_RDATA}),
        .pop   (do_pop),
        .flush (REDIRECT),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // During DISCARD fetch_pc keeps the abandoned address so IMEM_ADDR stays stable for the refill.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_FETCH;
            req_q      <= 1'b1;
            fetch_pc   <= RESET_PC;
            pending_pc <= '0;
        end else if (REDIRECT) begin
            req_q <= 1'b1;
            if (req_q && IMEM_BUSYWAIT) begin
                state      <= ST_DISCARD;
                pending_pc <= target_pc;
            end else begin
                state    <= ST_FETCH;
                fetch_pc <= target_pc;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (fetch_done) begin
                        fetch_pc <= fetch_pc + XLEN'(4);
                        if (count_next == DEPTH_C) begin
                            state <= ST_FULL;
                            req_q <= 1'b0;
                        end
                    end
                end
                ST_FULL: begin
                    // Decided on the registered count: a slot freed this edge is refilled next cycle.
                    if (!fifo_full) begin
                        state <= ST_FETCH;
                        req_q <= 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (!IMEM_BUSYWAIT) begin
                        state    <= ST_FETCH;
                        fetch_pc <= pending_pc;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                    req_q <= 1'b1;
                end
            endcase
        end
    end

    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = fetch_pc;

    assign OUT_VALID = !fifo_empty;
    assign OUT_PC    = fifo_empty ? '0 : head[2*XLEN-1:XLEN];
    assign OUT_INSTR = fifo_empty ? XLEN'(NOP_INSTR) : head[XLEN-1:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (req_q && IMEM_BUSYWAIT && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (REDIRECT && (flush_cnt != '1))               flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign PERF_STALL = stall_cnt;
    assign PERF_FLUSH = flush_cnt;
`else
    assign PERF_STALL = '0;
    assign PERF_FLUSH = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue_unit;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_busywait;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_queue_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .CLK           (clk),
        .RESET         (reset),
        .IMEM_REQ      (imem_req),
        .IMEM_ADDR     (imem_addr),
        .IMEM_RDATA    (imem_rdata),
        .IMEM_BUSYWAIT (imem_busywait),
        .REDIRECT      (redirect),
        .REDIRECT_PC   (redirect_pc),
        .OUT_VALID     (out_valid),
        .OUT_PC        (out_pc),
        .OUT_INSTR     (out_instr),
        .OUT_READY     (out_ready),
        .PERF_STALL    (perf_stall),
        .PERF_FLUSH    (perf_flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h1357, a[17:2]};
    endfunction

    // Reference model: queue of {pc,instr}, next fetch address, and two wait conditions.
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_pending;
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    bit          m_full_wait;
    bit          m_discard;

    task automatic model_reset();
        mq.delete();
        m_pc        = 32'h0;
        m_pending   = 32'h0;
        m_stall     = 32'h0;
        m_flush     = 32'h0;
        m_full_wait = 1'b0;
        m_discard   = 1'b0;
    endtask

    task automatic model_step(input bit redir, input logic [31:0] rpc, input bit busy, input bit ready);
        bit req;
        bit had_room;
        req = !m_full_wait;
        if (PERF_ON) begin
            if (req && busy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (redir && m_flush != 32'hFFFF_FFFF)       m_flush = m_flush + 1;
        end
        if (redir) begin
            mq.delete();
            m_full_wait = 1'b0;
            if (req && busy) begin
                m_discard = 1'b1;
                m_pending = rpc & 32'hFFFF_FFFC;
            end else begin
                m_discard = 1'b0;
                m_pc      = rpc & 32'hFFFF_FFFC;
            end
        end else if (m_discard) begin
            if (!busy) begin
                m_discard = 1'b0;
                m_pc      = m_pending;
            end
        end else if (m_full_wait) begin
            had_room = (mq.size() < DEPTH);
            if (ready && mq.size() > 0) void'(mq.pop_front());
            if (had_room) m_full_wait = 1'b0;
        end else begin
            if (ready && mq.size() > 0) void'(mq.pop_front());
            if (!busy) begin
                mq.push_back({m_pc, instr_of(m_pc)});
                m_pc = m_pc + 32'd4;
                if (mq.size() == DEPTH) m_full_wait = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        e_pc    = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
        e_instr = (mq.size() > 0) ? mq[0][31:0]  : NOP;
        check("m_imem_req",   32'(imem_req),  32'(!m_full_wait));
        check("m_imem_addr",  imem_addr,      m_pc);
        check("m_out_valid",  32'(out_valid), 32'(mq.size() > 0));
        check("m_out_pc",     out_pc,         e_pc);
        check("m_out_instr",  out_instr,      e_instr);
        check("m_perf_stall", perf_stall,     m_stall);
        check("m_perf_flush", perf_flush,     m_flush);
    endtask

    // One clock: drive inputs after the falling edge, check, advance the model, wait for the next falling edge.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit busy, input bit ready);
        redirect      = redir;
        redirect_pc   = rpc;
        imem_busywait = busy;
        out_ready     = ready;
        imem_rdata    = busy ? 32'hDEAD_BEEF : instr_of(imem_addr);
        #1;
        compare_model();
        model_step(redir, rpc, busy, ready);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit busy);
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        imem_busywait = busy;
        out_ready     = 1'($urandom_range(0, 1));
        imem_rdata    = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        bit          r;
        logic [31:0] rpc;

        // 1: streaming after reset
        do_reset(1'b0);
        #1;
        check("t1_req",    32'(imem_req),  32'd1);
        check("t1_addr0",  imem_addr,      32'h0);
        check("t1_valid0", 32'(out_valid), 32'd0);
        check("t1_instr0", out_instr,      NOP);
        check("t1_stall0", perf_stall,     32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t1_addr1",  imem_addr, 32'h4);
        check("t1_pc_a",   out_pc,    32'h0);
        check("t1_ins_a",  out_instr, instr_of(32'h0));
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t1_addr2",  imem_addr, 32'h8);
        check("t1_pc_b",   out_pc,    32'h4);
        check("t1_ins_b",  out_instr, instr_of(32'h4));
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // 2: five busy cycles at 0x10
        do_reset(1'b0);
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t2_addr", imem_addr, 32'h10);
        repeat (5) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("t2_addr_held", imem_addr,      32'h10);
        check("t2_no_push",   32'(out_valid), 32'd0);
        check("t2_stall",     perf_stall,     PERF_ON ? 32'd5 : 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t2_pc_after",  out_pc,    32'h10);
        check("t2_addr_next", imem_addr, 32'h14);

        // 3: fill with OUT_READY low, then a single pop
        do_reset(1'b0);
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("t3_req_full", 32'(imem_req), 32'd0);
        check("t3_head",     out_pc,        32'h0);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("t3_req_hold", 32'(imem_req), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t3_head_pop", out_pc,        32'h4);
        check("t3_req_wait", 32'(imem_req), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("t3_refetch_req",  32'(imem_req), 32'd1);
        check("t3_refetch_addr", imem_addr,     32'h10);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // 4: redirect with three entries queued (target has stray low bits)
        do_reset(1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("t4_head", out_pc, 32'h0);
        cycle(1'b1, 32'h101, 1'b0, 1'b0);
        check("t4_valid", 32'(out_valid), 32'd0);
        check("t4_addr",  imem_addr,      32'h100);
        check("t4_flush", perf_flush,     PERF_ON ? 32'd1 : 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("t4_pc", out_pc, 32'h100);

        // 5: redirect during refill of 0x40, then a second redirect mid-DISCARD
        do_reset(1'b0);
        repeat (16) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t5_addr40", imem_addr, 32'h40);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h200, 1'b1, 1'b1);
        check("t5_disc_addr",  imem_addr,      32'h40);
        check("t5_disc_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            check("t5_held", imem_addr, 32'h40);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t5_dropped", 32'(out_valid), 32'd0);
        check("t5_target",  imem_addr,      32'h200);
        cycle(1'b1, 32'h280, 1'b1, 1'b1);
        cycle(1'b1, 32'h300, 1'b1, 1'b1);
        check("t5_held2", imem_addr, 32'h200);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t5_target2", imem_addr,  32'h300);
        check("t5_flushes", perf_flush, PERF_ON ? 32'd3 : 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t5_pc", out_pc, 32'h300);

        // 6: redirect coinciding with a completing fetch and a pop
        do_reset(1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t6_head", out_pc, 32'h8);
        cycle(1'b1, 32'h400, 1'b0, 1'b1);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_instr", out_instr,      NOP);
        check("t6_addr",  imem_addr,      32'h400);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("t6_pc", out_pc, 32'h400);

        // fetch_pc wraps modulo 2^32
        do_reset(1'b0);
        cycle(1'b1, 32'hFFFF_FFFA, 1'b0, 1'b1);
        check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc",   out_pc,    32'hFFFF_FFFC);

        // randomized traffic, including resets during refills
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
            r = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                           rpc = $urandom & 32'h0000_0FFF;
            cycle(r, rpc, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
